// File: rtl/csa64_multiprecision_seq_pkg.sv
// Shared constants for the multiprecision add/sub sequencer.
// Includes the limb width, the FSM encodings and the counter sizing helper.
package csa64_multiprecision_seq_pkg;

  localparam int unsigned LIMB_W = 64;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef logic [LIMB_W-1:0] limb_t;

  function automatic int unsigned cnt_width(input int unsigned limbs);
    return (limbs <= 1) ? 1 : $clog2(limbs);
  endfunction

endpackage

// File: rtl/csa64_multiprecision_seq_if.sv
// Request/result handshake bundle between the accumulators and the wide add/sub sequencer.
interface csa64_multiprecision_seq_if #(
  parameter int unsigned LIMBS = 4
);
  import csa64_multiprecision_seq_pkg::*;

  localparam int unsigned W = LIMB_W * LIMBS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/csa64_multiprecision_seq_adder.sv
// 64-bit carry-select adder: 16-bit ripple blocks, each upper block precomputes
// both carry-in cases and the incoming carry selects between them.
module carry_select_adder_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  localparam int unsigned BLK = 16;
  localparam int unsigned NB  = 64 / BLK;

  logic [BLK:0] r0 [NB];
  logic [BLK:0] r1 [NB];
  logic [NB:0]  c;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    assign r0[g] = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
    assign r1[g] = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
  end

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < NB; i++) begin
      sum[i*BLK +: BLK] = c[i] ? r1[i][BLK-1:0] : r0[i][BLK-1:0];
      c[i+1]            = c[i] ? r1[i][BLK]     : r0[i][BLK];
    end
    cout = c[NB];
  end

endmodule

// File: rtl/csa64_multiprecision_seq.sv
// Wide add/subtract sequencer: streams LIMBS 64-bit limbs, LS first, through one
// shared carry-select adder with the carry registered between limbs.
module csa64_multiprecision_seq
  import csa64_multiprecision_seq_pkg::*;
#(
  parameter int unsigned LIMBS = 4
) (
  input logic                      clk,
  input logic                      rst,
  csa64_multiprecision_seq_if.slave bus
);

  localparam int unsigned W  = LIMB_W * LIMBS;
  localparam int unsigned CW = cnt_width(LIMBS);
  localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;

  limb_t add_sum;
  logic  add_cout;

  // Operands shift down one limb per RUN cycle so the adder always sees bits [63:0].
  carry_select_adder_64 u_adder (
    .a    (a_q[LIMB_W-1:0]),
    .b    (b_q[LIMB_W-1:0]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is folded into A + ~B + 1 at latch time.
            a_q   <= bus.in_a;
            b_q   <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry <= bus.in_sub ? 1'b1 : bus.in_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[LIMB_W*cnt +: LIMB_W] <= add_sum;
          carry <= add_cout;
          a_q   <= a_q >> LIMB_W;
          b_q   <= b_q >> LIMB_W;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            cout_q <= add_cout;
            ovf_q  <= (a_q[LIMB_W-1] == b_q[LIMB_W-1]) &&
                      (add_sum[LIMB_W-1] != a_q[LIMB_W-1]);
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa64_multiprecision_seq.sv
// Scoreboard bench for the wide add/sub sequencer at LIMBS=4 (256-bit operands).
module tb_csa64_multiprecision_seq;
  import csa64_multiprecision_seq_pkg::*;

  localparam int unsigned LIMBS = 4;
  localparam int unsigned W     = LIMB_W * LIMBS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  csa64_multiprecision_seq_if #(.LIMBS(LIMBS)) bus ();

  csa64_multiprecision_seq #(.LIMBS(LIMBS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] bb;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, W'(sb.size()), W'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"},  bus.out_sum,         e.sum);
      check({tag, "_cout"}, W'(bus.out_cout),    W'(e.cout));
      check({tag, "_ovf"},  W'(bus.out_ovf),     W'(e.ovf));
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int unsigned stall, input string tag);
    int unsigned k;
    exp_t        e;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.in_sub    = sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    e = model(a, b, cin, sub);
    sb.push_back(e);
    // Requests during RUN carry different operands and must be ignored
    bus.in_valid = (stall != 0);
    bus.in_a     = ~a;
    bus.in_b     = a;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, W'(k), W'(LIMBS));
    check({tag, "_in_ready_done"}, W'(bus.in_ready), '0);
    compare_out(tag);
    for (int unsigned i = 0; i < stall; i++) begin
      bus.in_valid = i[0];
      @(posedge clk); #1;
      check({tag, "_hold_valid"},    W'(bus.out_valid), W'(1));
      check({tag, "_hold_in_ready"}, W'(bus.in_ready),  '0);
      check({tag, "_hold_sum"},      bus.out_sum,       e.sum);
      check({tag, "_hold_cout"},     W'(bus.out_cout),  W'(e.cout));
      check({tag, "_hold_ovf"},      W'(bus.out_ovf),   W'(e.ovf));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_clr"}, W'(bus.out_valid), '0);
    check({tag, "_idle_ready"}, W'(bus.in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] smax;
    ones = '1;
    smax = {1'b0, {(W-1){1'b1}}};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  W'(bus.in_ready),  W'(1));
    check("rst_out_valid", W'(bus.out_valid), '0);
    check("rst_sum",       bus.out_sum,       '0);
    check("rst_cout",      W'(bus.out_cout),  '0);
    check("rst_ovf",       W'(bus.out_ovf),   '0);
    rst = 1'b0;

    run_op(W'(1), W'(2), 1'b0, 1'b0, 0, "add_simple");
    run_op(ones,  '0,    1'b1, 1'b0, 0, "ripple");
    run_op('0,    W'(1), 1'b0, 1'b1, 0, "sub_borrow");
    run_op(smax,  W'(1), 1'b0, 1'b0, 0, "sovf");
    run_op(rand_op(), rand_op(), 1'b1, 1'b0, 5, "backpressure");
    for (int i = 0; i < 4; i++) begin
      run_op(rand_op(), rand_op(), i[0], i[1], 0, "random");
    end
    run_op(W'(9), rand_op(), 1'b1, 1'b1, 0, "sub_ignores_cin");

    // Abort an op after two limbs; no result may appear
    bus.in_a     = ones;
    bus.in_b     = '0;
    bus.in_cin   = 1'b1;
    bus.in_sub   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", W'(bus.out_valid), '0);
    check("abort_in_ready",  W'(bus.in_ready),  W'(1));
    check("abort_sum",       bus.out_sum,       '0);
    check("abort_cout",      W'(bus.out_cout),  '0);
    run_op(W'(5), W'(7), 1'b0, 1'b0, 0, "after_abort");

    // Reset and request on the same edge: the request must be dropped
    rst          = 1'b1;
    bus.in_a     = W'(1);
    bus.in_b     = W'(1);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < int'(LIMBS) + 2; i++) begin
      check("rst_vs_req_ready", W'(bus.in_ready),  W'(1));
      check("rst_vs_req_valid", W'(bus.out_valid), '0);
      @(posedge clk); #1;
    end

    check("sb_drained", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
